// File: rtl/misty_pkg.sv
// ============================================================================
// Module   : misty_pkg
// Brief    : Shared MISTY1 round-key types, beat constants and index helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package misty_pkg;

    typedef logic [15:0] key16_t;

    localparam int NUM_BEATS = 9;

    // Beats 0,2,4,6,8 carry an FL key pair.
    localparam logic [NUM_BEATS-1:0] FL_BEAT_MASK = 9'b1_0101_0101;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOADED = 2'd1,
        ST_SEQ    = 2'd2
    } state_t;

    typedef struct packed {
        key16_t k1;
        key16_t k2;
        key16_t k3;
        key16_t k4;
    } ko_t;

    typedef struct packed {
        key16_t k1;
        key16_t k2;
        key16_t k3;
    } ki_t;

    typedef struct packed {
        key16_t a1;
        key16_t a2;
        key16_t b1;
        key16_t b2;
    } fl_t;

    // Key indices run 1..8 and wrap: 9 -> 1, 15 -> 7.
    function automatic int idx8(input int n);
        return ((n - 1) % 8) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/misty_rk_select.sv
// ============================================================================
// Module   : misty_rk_select
// Brief    : Combinational subkey selector: beat index + key bank in,
//            packed KO/KI/FL subkeys out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module misty_rk_select
    import misty_pkg::*;
(
    input  logic [3:0]   beat_i,
    input  logic [255:0] bank_i,
    output ko_t          ko_o,
    output ki_t          ki_o,
    output fl_t          fl_o,
    output logic         fl_en_o
);

    int round_n;
    int half_n;

    // K(n): bank[255:128] holds K1..K8 with K1 in the top word.
    function automatic key16_t k_word(input logic [255:0] bank, input int n);
        return bank[255 - 16*(idx8(n) - 1) -: 16];
    endfunction

    // K'(n): bank[127:0] holds K'1..K'8 with K'1 in the top word.
    function automatic key16_t kp_word(input logic [255:0] bank, input int n);
        return bank[127 - 16*(idx8(n) - 1) -: 16];
    endfunction

    // Select the round keys and, on even beats, the FL pair FL(b+1)/FL(b+2).
    always_comb begin
        ko_o    = '0;
        ki_o    = '0;
        fl_o    = '0;
        fl_en_o = 1'b0;
        round_n = int'(beat_i) + 1;
        half_n  = int'(beat_i) / 2;
        if (beat_i < 4'(NUM_BEATS)) begin
            // The last beat carries only the final FL layer.
            if (beat_i != 4'(NUM_BEATS - 1)) begin
                ko_o.k1 = k_word(bank_i, round_n);
                ko_o.k2 = k_word(bank_i, round_n + 2);
                ko_o.k3 = k_word(bank_i, round_n + 7);
                ko_o.k4 = k_word(bank_i, round_n + 4);
                ki_o.k1 = kp_word(bank_i, round_n + 5);
                ki_o.k2 = kp_word(bank_i, round_n + 1);
                ki_o.k3 = kp_word(bank_i, round_n + 3);
            end
            fl_en_o = FL_BEAT_MASK[beat_i];
            if (FL_BEAT_MASK[beat_i]) begin
                // Odd FL index i=b+1 and even FL index i=b+2, both with (i+1)/2 = b/2+1.
                fl_o.a1 = k_word(bank_i, half_n + 1);
                fl_o.a2 = kp_word(bank_i, half_n + 7);
                fl_o.b1 = kp_word(bank_i, half_n + 3);
                fl_o.b2 = k_word(bank_i, half_n + 5);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/misty_round_keys.sv
// ============================================================================
// Module   : misty_round_keys
// Brief    : Latches the MISTY1 expanded key bank and streams per-round
//            KO/KI/KL subkeys over a valid/ready handshake, one beat/round.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module misty_round_keys
    import misty_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_i,
    input  logic [255:0] expand_keys_i,
    input  logic         start_i,
    input  logic         rk_ready_i,
    output logic         keys_ready_o,
    output logic         rk_valid_o,
    output logic [3:0]   beat_o,
    output logic [63:0]  ko_o,
    output logic [47:0]  ki_o,
    output logic         fl_en_o,
    output logic [63:0]  fl_o,
    output logic         done_o
);

    localparam logic [3:0] LAST_BEAT = 4'(NUM_BEATS - 1);

    state_t         state_q, state_d;
    logic [3:0]     beat_q, beat_d;
    logic [255:0]   bank_q, bank_d;

    logic           keys_ready_q, keys_ready_d;
    logic           rk_valid_q, rk_valid_d;
    logic [3:0]     beat_out_q, beat_out_d;
    logic [63:0]    ko_q, ko_d;
    logic [47:0]    ki_q, ki_d;
    logic           fl_en_q, fl_en_d;
    logic [63:0]    fl_q, fl_d;
    logic           done_q, done_d;

    ko_t            sel_ko;
    ki_t            sel_ki;
    fl_t            sel_fl;
    logic           sel_fl_en;

    // Subkeys are selected from the next beat so the output registers
    // present them in the same cycle the FSM enters or advances SEQ.
    misty_rk_select u_select (
        .beat_i  (beat_d),
        .bank_i  (bank_q),
        .ko_o    (sel_ko),
        .ki_o    (sel_ki),
        .fl_o    (sel_fl),
        .fl_en_o (sel_fl_en)
    );

    // State, beat counter and key bank registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            beat_q  <= 4'd0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            bank_q  <= bank_d;
        end
    end

    // Next-state logic: a key load always wins over start or beat progress.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        bank_d  = bank_q;
        case (state_q)
            ST_EMPTY: begin
                if (valid_i) begin
                    bank_d  = expand_keys_i;
                    state_d = ST_LOADED;
                end
            end
            ST_LOADED: begin
                if (valid_i) begin
                    bank_d = expand_keys_i;
                end else if (start_i) begin
                    state_d = ST_SEQ;
                    beat_d  = 4'd0;
                end
            end
            ST_SEQ: begin
                if (valid_i) begin
                    bank_d  = expand_keys_i;
                    state_d = ST_LOADED;
                    beat_d  = 4'd0;
                end else if (rk_valid_q && rk_ready_i) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_LOADED;
                        beat_d  = 4'd0;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
                beat_d  = 4'd0;
            end
        endcase
    end

    // Output values for the next cycle; data is zero whenever no beat is valid.
    always_comb begin
        keys_ready_d = (state_d == ST_LOADED);
        rk_valid_d   = (state_d == ST_SEQ);
        done_d       = (state_q == ST_SEQ) && !valid_i && rk_valid_q &&
                       rk_ready_i && (beat_q == LAST_BEAT);
        beat_out_d   = 4'd0;
        ko_d         = '0;
        ki_d         = '0;
        fl_en_d      = 1'b0;
        fl_d         = '0;
        if (state_d == ST_SEQ) begin
            beat_out_d = beat_d;
            ko_d       = sel_ko;
            ki_d       = sel_ki;
            fl_en_d    = sel_fl_en;
            fl_d       = sel_fl;
        end
    end

    // Output registers: no combinational path from inputs to outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            keys_ready_q <= 1'b0;
            rk_valid_q   <= 1'b0;
            beat_out_q   <= 4'd0;
            ko_q         <= '0;
            ki_q         <= '0;
            fl_en_q      <= 1'b0;
            fl_q         <= '0;
            done_q       <= 1'b0;
        end else begin
            keys_ready_q <= keys_ready_d;
            rk_valid_q   <= rk_valid_d;
            beat_out_q   <= beat_out_d;
            ko_q         <= ko_d;
            ki_q         <= ki_d;
            fl_en_q      <= fl_en_d;
            fl_q         <= fl_d;
            done_q       <= done_d;
        end
    end

    assign keys_ready_o = keys_ready_q;
    assign rk_valid_o   = rk_valid_q;
    assign beat_o       = beat_out_q;
    assign ko_o         = ko_q;
    assign ki_o         = ki_q;
    assign fl_en_o      = fl_en_q;
    assign fl_o         = fl_q;
    assign done_o       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_misty_round_keys.sv
// ============================================================================
// Module   : tb_misty_round_keys
// Brief    : Self-checking bench for misty_round_keys against a key-schedule
//            reference model built from the MISTY1 round/FL index rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_misty_round_keys;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_i;
    logic [255:0] expand_keys_i;
    logic         start_i;
    logic         rk_ready_i;
    logic         keys_ready_o;
    logic         rk_valid_o;
    logic [3:0]   beat_o;
    logic [63:0]  ko_o;
    logic [47:0]  ki_o;
    logic         fl_en_o;
    logic [63:0]  fl_o;
    logic         done_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] mK  [1:8];
    logic [15:0] mKP [1:8];

    wire [181:0] obs = {rk_valid_o, beat_o, ko_o, ki_o, fl_en_o, fl_o};
    wire [183:0] all_out = {keys_ready_o, done_o, obs};

    misty_round_keys dut (
        .clk           (clk),
        .reset         (reset),
        .valid_i       (valid_i),
        .expand_keys_i (expand_keys_i),
        .start_i       (start_i),
        .rk_ready_i    (rk_ready_i),
        .keys_ready_o  (keys_ready_o),
        .rk_valid_o    (rk_valid_o),
        .beat_o        (beat_o),
        .ko_o          (ko_o),
        .ki_o          (ki_o),
        .fl_en_o       (fl_en_o),
        .fl_o          (fl_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int w8(input int n);
        return ((n - 1) % 8) + 1;
    endfunction

    function automatic logic [15:0] kl1(input int i);
        if (i % 2 == 1) return mK[w8((i + 1) / 2)];
        else            return mKP[w8(i / 2 + 2)];
    endfunction

    function automatic logic [15:0] kl2(input int i);
        if (i % 2 == 1) return mKP[w8((i + 1) / 2 + 6)];
        else            return mK[w8(i / 2 + 4)];
    endfunction

    // Expected {rk_valid, beat, ko, ki, fl_en, fl} for beat b.
    function automatic logic [181:0] model_beat(input int b);
        logic [63:0] ko;
        logic [47:0] ki;
        logic [63:0] fl;
        logic        fe;
        int          r;
        r  = b + 1;
        ko = '0;
        ki = '0;
        fl = '0;
        if (b < 8) begin
            ko = {mK[w8(r)], mK[w8(r + 2)], mK[w8(r + 7)], mK[w8(r + 4)]};
            ki = {mKP[w8(r + 5)], mKP[w8(r + 1)], mKP[w8(r + 3)]};
        end
        fe = (b % 2 == 0);
        if (fe) fl = {kl1(b + 1), kl2(b + 1), kl1(b + 2), kl2(b + 2)};
        return {1'b1, 4'(b), ko, ki, fe, fl};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bank();
        for (int i = 1; i <= 8; i++) begin
            expand_keys_i[255 - 16*(i-1) -: 16] = mK[i];
            expand_keys_i[127 - 16*(i-1) -: 16] = mKP[i];
        end
    endtask

    task automatic synth_bank();
        for (int i = 1; i <= 8; i++) begin
            mK[i]  = 16'h1000 + 16'(i);
            mKP[i] = 16'h2000 + 16'(i);
        end
    endtask

    task automatic random_bank();
        for (int i = 1; i <= 8; i++) begin
            mK[i]  = 16'($urandom);
            mKP[i] = 16'($urandom);
        end
    endtask

    task automatic load_bank();
        drive_bank();
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, need 0", all_out);
        end
    endtask

    task automatic test_empty_start();
        pulse_start();
        step();
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL empty_start: got %h, need 0", all_out);
        end
        synth_bank();
        drive_bank();
        valid_i = 1'b1;
        start_i = 1'b1;
        step();
        valid_i = 1'b0;
        start_i = 1'b0;
        checks++;
        if (keys_ready_o !== 1'b1 || rk_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL valid_start_same: keys_ready=%b rk_valid=%b, need 1/0", keys_ready_o, rk_valid_o);
        end
        step();
        checks++;
        if (rk_valid_o !== 1'b0 || keys_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL valid_start_same_later: keys_ready=%b rk_valid=%b, need 1/0", keys_ready_o, rk_valid_o);
        end
    endtask

    task automatic test_synthetic();
        int cyc;
        synth_bank();
        load_bank();
        rk_ready_i = 1'b1;
        pulse_start();
        cyc = 1;
        checks++;
        if (ko_o !== 64'h1001_1003_1008_1005 || ki_o !== 48'h2006_2002_2004 ||
            fl_o !== 64'h1001_2007_2003_1005 || keys_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL synth_beat0: ko=%h ki=%h fl=%h kr=%b, need 1001100310081005 200620022004 1001200720031005 0",
                     ko_o, ki_o, fl_o, keys_ready_o);
        end
        for (int b = 0; b < 9; b++) begin
            checks++;
            if (obs !== model_beat(b) || done_o !== 1'b0) begin
                errors++;
                $display("FAIL synth_beat%0d: got %h done=%b, need %h done=0", b, obs, done_o, model_beat(b));
            end
            if (b == 7) begin
                checks++;
                if (ko_o !== 64'h1008_1002_1007_1004 || ki_o !== 48'h2005_2001_2003 || fl_en_o !== 1'b0) begin
                    errors++;
                    $display("FAIL synth_beat7_const: ko=%h ki=%h fl_en=%b", ko_o, ki_o, fl_en_o);
                end
            end
            if (b == 8) begin
                checks++;
                if (fl_o !== 64'h1005_2003_2007_1001 || ko_o !== 64'h0 || ki_o !== 48'h0 || fl_en_o !== 1'b1) begin
                    errors++;
                    $display("FAIL synth_beat8_const: fl=%h ko=%h ki=%h fl_en=%b", fl_o, ko_o, ki_o, fl_en_o);
                end
            end
            step();
            cyc++;
        end
        checks++;
        if (cyc != 10 || done_o !== 1'b1 || rk_valid_o !== 1'b0 || keys_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL synth_done: cyc=%0d done=%b rk_valid=%b kr=%b, need 10/1/0/1", cyc, done_o, rk_valid_o, keys_ready_o);
        end
        step();
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL synth_done_pulse: done=%b, need 0", done_o);
        end
    endtask

    task automatic test_stall();
        int exp_b;
        int stall;
        random_bank();
        load_bank();
        pulse_start();
        exp_b = 0;
        stall = 0;
        for (int c = 0; c < 40 && exp_b < 9; c++) begin
            checks++;
            if (obs !== model_beat(exp_b) || done_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_beat%0d: got %h done=%b, need %h", exp_b, obs, done_o, model_beat(exp_b));
            end
            rk_ready_i = !(exp_b == 4 && stall < 3);
            if (exp_b == 4 && stall < 3) stall++;
            step();
            if (rk_ready_i) exp_b++;
        end
        rk_ready_i = 1'b1;
        checks++;
        if (exp_b != 9 || stall != 3 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: beats=%0d stalls=%0d done=%b, need 9/3/1", exp_b, stall, done_o);
        end
        step();
    endtask

    task automatic test_abort();
        random_bank();
        load_bank();
        rk_ready_i = 1'b1;
        pulse_start();
        for (int b = 0; b < 3; b++) step();
        checks++;
        if (obs !== model_beat(3)) begin
            errors++;
            $display("FAIL abort_beat3: got %h, need %h", obs, model_beat(3));
        end
        random_bank();
        drive_bank();
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        checks++;
        if (rk_valid_o !== 1'b0 || keys_ready_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_next: rk_valid=%b kr=%b done=%b, need 0/1/0", rk_valid_o, keys_ready_o, done_o);
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (done_o !== 1'b0 || rk_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet: done=%b rk_valid=%b, need 0/0", done_o, rk_valid_o);
            end
            step();
        end
        pulse_start();
        checks++;
        if (obs !== model_beat(0)) begin
            errors++;
            $display("FAIL abort_newbank: got %h, need %h", obs, model_beat(0));
        end
        for (int b = 0; b < 10; b++) step();
    endtask

    task automatic test_reset_mid();
        random_bank();
        load_bank();
        rk_ready_i = 1'b1;
        pulse_start();
        for (int b = 0; b < 5; b++) step();
        checks++;
        if (beat_o !== 4'd5) begin
            errors++;
            $display("FAIL reset_mid_pre: beat=%0d, need 5", beat_o);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_mid: got %h, need 0", all_out);
        end
        pulse_start();
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (all_out !== '0) begin
                errors++;
                $display("FAIL reset_mid_start: got %h, need 0", all_out);
            end
            step();
        end
        load_bank();
        checks++;
        if (keys_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_reload: kr=%b, need 1", keys_ready_o);
        end
    endtask

    task automatic test_random();
        int exp_b;
        for (int n = 0; n < 6; n++) begin
            random_bank();
            load_bank();
            pulse_start();
            exp_b = 0;
            for (int c = 0; c < 200 && exp_b < 9; c++) begin
                checks++;
                if (obs !== model_beat(exp_b) || done_o !== 1'b0 || keys_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d: got %h done=%b kr=%b, need %h", n, exp_b, obs, done_o,
                             keys_ready_o, model_beat(exp_b));
                end
                rk_ready_i = ($urandom_range(0, 9) < 7);
                start_i    = ($urandom_range(0, 3) == 0);
                step();
                if (rk_ready_i) exp_b++;
            end
            start_i    = 1'b0;
            rk_ready_i = 1'b1;
            checks++;
            if (exp_b != 9 || done_o !== 1'b1 || rk_valid_o !== 1'b0 || keys_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d_done: beats=%0d done=%b rk_valid=%b kr=%b", n, exp_b, done_o, rk_valid_o, keys_ready_o);
            end
            step();
        end
    endtask

    initial begin
        reset         = 1'b1;
        valid_i       = 1'b0;
        start_i       = 1'b0;
        rk_ready_i    = 1'b0;
        expand_keys_i = '0;
        test_reset();
        test_empty_start();
        test_synthetic();
        test_stall();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
